// File: rtl/uart_div_pkg.sv
// uart_div_pkg: shared FSM encoding, byte-count helper and default timeout for the UART divider.
package uart_div_pkg;
   typedef enum logic [1:0] {
      S_RX      = 2'd0,
      S_DIV     = 2'd1,
      S_TX_LOAD = 2'd2,
      S_TX_WAIT = 2'd3
   } state_t;
   localparam int TIMEOUT_DEF = 500000;
   function automatic int nb(input int w);
      return w / 8;
   endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle; divisor 0 finishes in the start cycle.
module seq_divider
   import uart_div_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_dividend,
   input  logic [DATA_W-1:0] i_divisor,
   output logic              o_done,
   output logic              o_dz,
   output logic [DATA_W-1:0] o_quot,
   output logic [DATA_W-1:0] o_rem
);
   localparam int CW = $clog2(DATA_W);
   logic                r_run;
   logic [CW-1:0]       r_cnt;
   logic [2*DATA_W-1:0] r_pr;
   logic [DATA_W-1:0]   r_dvs;
   logic                w_first, w_zero, w_ge;
   logic [DATA_W-1:0]   w_dvs;
   logic [2*DATA_W-1:0] w_cur, w_step;
   logic [DATA_W:0]     w_hi, w_diff;
   // The first step works straight off the inputs so no load cycle is spent.
   assign w_first = i_start && !r_run;
   assign w_zero  = w_first && (i_divisor == '0);
   assign w_dvs   = w_first ? i_divisor : r_dvs;
   assign w_cur   = w_first ? {{DATA_W{1'b0}}, i_dividend} : r_pr;
   assign w_hi    = w_cur[2*DATA_W-1:DATA_W-1];
   assign w_diff  = w_hi - {1'b0, w_dvs};
   assign w_ge    = !w_diff[DATA_W];
   assign w_step  = {w_ge ? w_diff[DATA_W-1:0] : w_hi[DATA_W-1:0], w_cur[DATA_W-2:0], w_ge};
   assign o_done  = w_zero || (r_run && r_cnt == CW'(DATA_W-1));
   assign o_dz    = w_zero;
   assign o_quot  = w_zero ? '1 : w_step[DATA_W-1:0];
   assign o_rem   = w_zero ? i_dividend : w_step[2*DATA_W-1:DATA_W];
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_pr  <= '0;
         r_dvs <= '0;
      end else if (w_first && !w_zero) begin
         r_run <= 1'b1;
         r_cnt <= CW'(1);
         r_pr  <= w_step;
         r_dvs <= i_divisor;
      end else if (r_run) begin
         r_run <= r_cnt != CW'(DATA_W-1);
         r_cnt <= r_cnt + 1'b1;
         r_pr  <= w_step;
      end
   end
endmodule

// File: rtl/uart_div_ctrl.sv
// uart_div_ctrl: gathers a dividend/divisor byte frame, divides, streams quotient and remainder back.
// Define UART_DIV_CHK_EN to append an XOR checksum byte to each response.
module uart_div_ctrl
   import uart_div_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic [DATA_W-1:0] quot,
   output logic [DATA_W-1:0] rem,
   output logic              div_zero,
   output logic              busy
);
   localparam int NB = nb(DATA_W);
`ifdef UART_DIV_CHK_EN
   localparam int NBYTES = 2*NB + 1;
`else
   localparam int NBYTES = 2*NB;
`endif
   localparam int IW = $clog2(NBYTES);
   state_t              r_state, w_nxt;
   logic [IW-1:0]       r_idx;
   logic [31:0]         r_to;
   logic                r_skip;
   logic [2*DATA_W-1:0] r_buf;
   logic [8*NBYTES-1:0] r_tx, w_tx_load;
   logic                w_div_start, w_div_done, w_div_dz;
   logic [DATA_W-1:0]   w_div_q, w_div_r;
   logic                w_rx_last, w_tx_last, w_tx_adv, w_timeout;
`ifdef UART_DIV_CHK_EN
   logic [7:0] w_chk;
   always_comb begin
      w_chk = '0;
      for (int i = 0; i < 2*NB; i++) w_chk ^= {w_div_r, w_div_q}[8*i +: 8];
   end
   assign w_tx_load = {w_chk, w_div_r, w_div_q};
`else
   assign w_tx_load = {w_div_r, w_div_q};
`endif
   assign w_rx_last   = r_idx == IW'(2*NB-1);
   assign w_tx_last   = r_idx == IW'(NBYTES-1);
   assign w_tx_adv    = r_state == S_TX_WAIT && !r_skip && !tx_busy;
   assign w_timeout   = TIMEOUT_CYC != 0 && r_to == 32'(TIMEOUT_CYC-1);
   assign w_div_start = r_state == S_DIV;
   assign busy        = r_state != S_RX;
   assign tx_data     = r_tx[7:0];
   seq_divider #(.DATA_W(DATA_W)) u_div (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_div_start),
      .i_dividend (r_buf[DATA_W-1:0]),
      .i_divisor  (r_buf[2*DATA_W-1:DATA_W]),
      .o_done     (w_div_done),
      .o_dz       (w_div_dz),
      .o_quot     (w_div_q),
      .o_rem      (w_div_r)
   );
   always_comb begin
      w_nxt    = r_state;
      tx_start = 1'b0;
      case (r_state)
         S_RX:      w_nxt = rx_valid && w_rx_last ? S_DIV : S_RX;
         S_DIV:     w_nxt = w_div_done ? S_TX_LOAD : S_DIV;
         S_TX_LOAD: begin
            tx_start = !tx_busy;
            w_nxt    = tx_busy ? S_TX_LOAD : S_TX_WAIT;
         end
         S_TX_WAIT: w_nxt = w_tx_adv ? (w_tx_last ? S_RX : S_TX_LOAD) : S_TX_WAIT;
         default:   w_nxt = S_RX;
      endcase
   end
   // Bytes shift in from the top so the first (LSB) byte ends at bit 0; responses shift out the same way.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_RX;
         r_idx    <= '0;
         r_to     <= '0;
         r_skip   <= 1'b0;
         r_buf    <= '0;
         r_tx     <= '0;
         quot     <= '0;
         rem      <= '0;
         div_zero <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_skip  <= tx_start;
         if (r_state == S_RX && rx_valid) begin
            r_buf <= {rx_data, r_buf[2*DATA_W-1:8]};
            r_idx <= w_rx_last ? '0 : r_idx + 1'b1;
            r_to  <= '0;
         end else if (r_state == S_RX && r_idx != '0 && TIMEOUT_CYC != 0) begin
            r_idx <= w_timeout ? '0 : r_idx;
            r_to  <= w_timeout ? '0 : r_to + 32'd1;
         end else if (w_tx_adv) begin
            r_idx <= w_tx_last ? '0 : r_idx + 1'b1;
            r_tx  <= r_tx >> 8;
         end
         if (r_state == S_DIV && w_div_done) begin
            quot     <= w_div_q;
            rem      <= w_div_r;
            div_zero <= w_div_dz;
            r_tx     <= w_tx_load;
         end
      end
   end
endmodule

// File: tb/tb_uart_div_ctrl.sv
// tb_uart_div_ctrl: directed frames against a 16-bit and a 32-bit controller with a busy-handshake transmitter model.
module tb_uart_div_ctrl;
   localparam int TO = 40;
`ifdef UART_DIV_CHK_EN
   localparam int NR = 5;
   localparam int NR32 = 9;
`else
   localparam int NR = 4;
   localparam int NR32 = 8;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_busy = 1'b0;
   logic        tx_start, div_zero, busy;
   logic [7:0]  tx_data;
   logic [15:0] quot, rem;
   logic        rx_valid32 = 1'b0;
   logic [7:0]  rx_data32 = 8'h00;
   logic        tx_busy32 = 1'b0;
   logic        tx_start32, div_zero32, busy32;
   logic [7:0]  tx_data32;
   logic [31:0] quot32, rem32;
   int n_chk = 0, n_pass = 0, cyc = 0, busy_len = 2, viol = 0;
   int last_rx_cyc = 0, first_tx_cyc = 0;
   logic [7:0] txq[$];
   logic [7:0] txq32[$];

   always #5 clk = ~clk;

   uart_div_ctrl #(.DATA_W(16), .TIMEOUT_CYC(TO)) u_dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
      .tx_start(tx_start), .tx_data(tx_data), .quot(quot), .rem(rem), .div_zero(div_zero), .busy(busy)
   );
   uart_div_ctrl #(.DATA_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .rx_valid(rx_valid32), .rx_data(rx_data32), .tx_busy(tx_busy32),
      .tx_start(tx_start32), .tx_data(tx_data32), .quot(quot32), .rem(rem32), .div_zero(div_zero32), .busy(busy32)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Transmitter model: busy rises the cycle after tx_start and holds for busy_len cycles.
   initial forever begin
      @(negedge clk);
      if (tx_start) begin
         if (tx_busy) viol++;
         if (txq.size() == 0) first_tx_cyc = cyc;
         txq.push_back(tx_data);
         @(posedge clk);
         #1 tx_busy = 1'b1;
         for (int i = 0; i < busy_len; i++) begin
            @(negedge clk);
            if (tx_start || tx_data !== txq[$]) viol++;
         end
         @(posedge clk);
         #1 tx_busy = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (tx_start32) txq32.push_back(tx_data32);
   end

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data = b;
      last_rx_cyc = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] f);
      for (int i = 0; i < 4; i++) send_byte(f[8*i +: 8]);
   endtask

   task automatic wait_resp();
      int t = 0;
      while ((txq.size() < NR || busy) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check("resp_count", txq.size(), NR);
   endtask

   task automatic check_resp(input logic [15:0] q, input logic [15:0] r, input logic dz);
      logic [31:0] e;
      logic [7:0]  x;
      e = {r, q};
      x = 8'h00;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("tx_byte%0d", i), i < txq.size() ? txq[i] : 8'hxx, e[8*i +: 8]);
         x ^= e[8*i +: 8];
      end
`ifdef UART_DIV_CHK_EN
      check("tx_chk", txq.size() > 4 ? txq[4] : 8'hxx, x);
`endif
      check("quot", quot, q);
      check("rem", rem, r);
      check("div_zero", div_zero, dz);
   endtask

   task automatic check_reset();
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_quot", quot, 0);
      check("rst_rem", rem, 0);
      check("rst_div_zero", div_zero, 0);
      check("rst_busy", busy, 0);
   endtask

   initial begin
      logic [63:0] f32;
      logic [63:0] e32;
      int t;
      repeat (3) @(negedge clk);
      check_reset();
      rst = 1'b1;
      @(negedge clk);

      txq.delete();
      send_frame(32'h0007_03E8);
      wait_resp();
      check_resp(16'h008E, 16'h0006, 1'b0);
      check("latency_div", first_tx_cyc - last_rx_cyc, 17);

      txq.delete();
      send_frame(32'h0000_1234);
      wait_resp();
      check_resp(16'hFFFF, 16'h1234, 1'b1);
      check("latency_dz", first_tx_cyc - last_rx_cyc, 2);

      txq.delete();
      send_byte(8'hE8);
      send_byte(8'h03);
      repeat (TO-1) @(negedge clk);
      send_byte(8'h07);
      send_byte(8'h00);
      wait_resp();
      check_resp(16'h008E, 16'h0006, 1'b0);

      txq.delete();
      send_byte(8'hE8);
      send_byte(8'h03);
      repeat (TO) @(negedge clk);
      send_frame(32'h000A_0064);
      wait_resp();
      check_resp(16'h000A, 16'h0000, 1'b0);

      busy_len = 1000;
      txq.delete();
      send_frame(32'h0003_0064);
      t = 0;
      while (txq.size() < 1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      wait_resp();
      check_resp(16'h0021, 16'h0001, 1'b0);
      busy_len = 2;
      txq.delete();
      send_frame(32'h0007_03E8);
      wait_resp();
      check_resp(16'h008E, 16'h0006, 1'b0);

      txq.delete();
      send_frame(32'h0005_0064);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset();
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check("no_tx_after_rst", txq.size(), 0);
      send_frame(32'h0007_03E8);
      wait_resp();
      check_resp(16'h008E, 16'h0006, 1'b0);

      f32 = 64'h0000_0003_0001_86A0;
      for (int i = 0; i < 8; i++) begin
         rx_valid32 = 1'b1;
         rx_data32 = f32[8*i +: 8];
         @(negedge clk);
      end
      rx_valid32 = 1'b0;
      t = 0;
      while ((txq32.size() < NR32 || busy32) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("resp32_count", txq32.size(), NR32);
      check("quot32", quot32, 32'h0000_8235);
      check("rem32", rem32, 32'h0000_0001);
      e32 = 64'h0000_0001_0000_8235;
      for (int i = 0; i < 8; i++)
         check($sformatf("tx32_byte%0d", i), i < txq32.size() ? txq32[i] : 8'hxx, e32[8*i +: 8]);
`ifdef UART_DIV_CHK_EN
      check("tx32_chk", txq32.size() > 8 ? txq32[8] : 8'hxx, 8'hB6);
`endif

      check("no_start_while_busy", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_div_ctrl.md
Name: uart_div_ctrl

Overview:
Parametrised UART-side controller for the divider task. It gathers a fixed-length operand frame from the UART receiver and runs a restoring divide, one quotient bit per cycle. It then streams quotient and remainder back through the UART transmitter. Sits between uart_rx and uart_tx. Pacing uses the transmitter's busy handshake, not a fixed baud-period timer.

Parameters:
DATA_W, 16, operand/result width in bits; must be a multiple of 8 and in the range 8..64
TIMEOUT_CYC, 500000, idle clk cycles after which a partially received frame is discarded; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
rx_valid  in  1  one-cycle pulse: rx_data holds a new byte
rx_data  in  8  received byte
tx_busy  in  1  transmitter busy; rises the cycle after tx_start and stays high until the byte is sent
tx_start  out  1  one-cycle pulse: send tx_data
tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls
quot  out  DATA_W  last quotient; held until the next result
rem  out  DATA_W  last remainder
div_zero  out  1  last division had divisor 0
busy  out  1  high in DIV, TX_LOAD and TX_WAIT

Behaviour:
- Reset (rst=0 at a clk edge) values: tx_start=0, tx_data=0, quot=0, rem=0, div_zero=0, busy=0. FSM goes to RX, byte index 0, timeout counter 0.
- Reset mid-division or mid-transmit aborts the operation. No further tx_start is issued.
- Frame: NB=DATA_W/8. Dividend arrives LSB byte first, then the divisor LSB byte first, so 2*NB bytes total.
- RX state:
  - Each rx_valid stores rx_data at the current byte index, increments the index and clears the timeout counter.
  - On the final byte: index returns to 0 and the next state is DIV.
  - With the index nonzero and no rx_valid, the timeout counter increments. At TIMEOUT_CYC the index resets to 0 and the partial frame is dropped. At index 0 the counter is held at 0.
- DIV state:
  - Divisor == 0: exactly 1 cycle. quot = all ones, rem = dividend, div_zero=1.
  - Otherwise: DATA_W cycles of restoring division on a 2*DATA_W partial-remainder register, comparison unsigned. Then quot and rem are loaded together and div_zero=0.
  - Latency from the last rx_valid to the first tx_start is DATA_W+1 cycles (2 cycles when dividing by zero).
- TX_LOAD:
  - Waits for tx_busy=0, then pulses tx_start for one cycle with tx_data = next response byte, and goes to TX_WAIT.
  - Response order: quot LSB..MSB, then rem LSB..MSB, so 2*NB bytes.
- TX_WAIT:
  - The cycle after tx_start is ignored, covering tx_busy latency.
  - Afterwards, when tx_busy=0: go to TX_LOAD if bytes remain, otherwise go to RX.
- rx_valid outside RX is ignored. Bytes are dropped and the index stays 0.
- tx_start is never asserted while tx_busy=1.
- quot, rem and div_zero change only at the end of DIV.

Optional Feature:
Macro UART_DIV_CHK_EN.
- Defined: one extra byte is appended to the response, the XOR of all 2*NB response bytes. It uses the same handshake, so total bytes = 2*NB+1.
- Undefined: no checksum logic, and the response is exactly 2*NB bytes.

Decomposition:
- Shared package uart_div_pkg holds:
  - FSM state encoding: RX=0, DIV=1, TX_LOAD=2, TX_WAIT=3.
  - A byte-count helper, NB = DATA_W/8.
  - The default timeout constant.
- One natural sub-module, seq_divider: start/done handshake, DATA_W-cycle restoring divider with a divide-by-zero output. Frame RX/TX sequencing stays in uart_div_ctrl.

Test Plan:
- DATA_W=16, bytes E8 03 07 00 (1000/7) -> quot=0x008E, rem=0x0006, div_zero=0. tx bytes 8E 00 06 00. First tx_start 17 cycles after the last rx_valid.
- Bytes 34 12 00 00 (divisor 0) -> quot=0xFFFF, rem=0x1234, div_zero=1. tx FF FF 34 12.
- Send E8 03, idle TIMEOUT_CYC cycles, then send 64 00 0A 00 -> quot=0x000A, rem=0. The stale bytes are discarded.
- Hold tx_busy high for 1000 cycles after each tx_start, and inject rx_valid bytes during TX -> no tx_start while busy. The injected bytes are ignored and the next frame decodes correctly.
- Pull rst low for 1 cycle mid-DIV -> all outputs return to reset values, no tx_start. A following frame E8 03 07 00 then produces the correct result.
- UART_DIV_CHK_EN with first frame -> tx 8E 00 06 00 88. DATA_W=32, 100000/3 -> quot=0x00008235, rem=1.
